spi_master_arb: RTL and testbench
=================================

Name: spi_master_arb

Overview:
- Two-requester SPI master controller. Arbitrates round-robin between two local requesters for a single SPI link.
- Generates sclk_o and cs_n_o and runs one 8-bit full-duplex mode-0 transfer per grant. Bits go MSB first, with a 3-bit down-counter running 7 to 0.
- Returns the received byte to the granted requester.
- Sits between on-chip request sources and the SPI slave (bit-counter-based receiver) on the board.

Parameters:
- CLK_DIV, 2: clk_i cycles per sclk half-period. Legal range is 1 or more; 0 is illegal. The divider counter width is $clog2(CLK_DIV+1).
- DATA_W, 8: transfer width. The bit counter is $clog2(DATA_W) bits. Only 8 is verified.

Ports:
- clk_i, input, 1: system clock; all logic on its rising edge.
- rst_i, input, 1: asynchronous, active-high reset.
- req_i, input, 2: per-requester transfer request. Level signal; must be held until the matching gnt_o bit.
- data0_i, input, DATA_W: transmit byte for requester 0. Sampled in its grant cycle.
- data1_i, input, DATA_W: transmit byte for requester 1. Sampled in its grant cycle.
- gnt_o, output, 2: one-hot, 1-cycle grant pulse.
- done_o, output, 2: one-hot, 1-cycle completion pulse.
- rdata_o, output, DATA_W: received byte. Valid in the done_o cycle and held until the next done_o.
- busy_o, output, 1: high from the grant cycle through the end of the GAP state.
- sclk_o, output, 1: SPI clock. Idles low.
- cs_n_o, output, 1: SPI chip select, active low.
- mosi_o, output, 1: serial data out.
- miso_i, input, 1: serial data in. Synchronous to sclk_o, which this block generates; no synchronizer.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - sclk_o=0, cs_n_o=1, mosi_o=0, gnt_o=0, done_o=0, busy_o=0, rdata_o=0.
  - Shift register = 0, bit counter = 7, divider = 0, state = IDLE, round-robin pointer = requester 0.
- All outputs are registered.
- FSM state IDLE:
  - If any req_i bit is set: choose a winner. Use the pointer's requester if it is requesting, else the other one.
  - On the next edge: go to SETUP, gnt_o[winner]=1 for that one cycle, cs_n_o=0, busy_o=1.
  - Load the shift register from the winner's data; mosi_o = bit 7. Bit counter = 7. Pointer = the other requester.
  - A req_i bit that drops before its grant is simply not served.
- SETUP: hold CLK_DIV cycles with sclk_o=0 (cs-to-first-edge setup), then go to XFER.
- XFER: sclk_o toggles every CLK_DIV cycles, giving 16 half-periods.
  - Rising edge of sclk_o: sample miso_i into the shift register LSB.
  - Falling edge of sclk_o: shift left; mosi_o = next bit; bit counter decrements.
  - The falling edge after the rising edge where bit counter == 0 ends XFER. On that edge: sclk_o=0, cs_n_o=1, done_o[winner]=1 for one cycle, rdata_o = shifted-in byte. Go to GAP.
  - cs_n_o is low for exactly 17*CLK_DIV cycles. Grant-to-done is 17*CLK_DIV cycles.
- GAP: cs_n_o high for CLK_DIV cycles, then IDLE with busy_o=0.
  - The earliest next grant is 1 cycle after entering IDLE.
  - Grant-to-next-grant minimum is 18*CLK_DIV + 1 cycles.
- Requests arriving while busy_o=1 are ignored until IDLE; no queueing inside the block.
- Both requests in the same IDLE cycle: the pointer decides. Fairness: strict alternation when both are continuously requesting.
- mosi_o = 0 whenever cs_n_o = 1.

Test Plan:
- CLK_DIV=2, miso_i looped to mosi_o, req_i=01, data0_i=0xA5:
  - gnt_o=01 once; mosi_o sequence 1,0,1,0,0,1,0,1 across 8 sclk rising edges.
  - cs_n_o low for 34 cycles; done_o=01 34 cycles after the grant with rdata_o=0xA5.
  - busy_o falls 2 cycles after done_o.
- miso_i tied 1, data1_i=0x00, req_i=10 -> all mosi_o bits 0; done_o=10; rdata_o=0xFF.
- After reset, req_i=11 held with CLK_DIV=1:
  - Grants in order 01, 10, 01, 10.
  - Each next grant is 19 cycles after the previous one.
  - No transfer overlaps another.
- req_i[1] raised 5 cycles into a requester-0 transfer:
  - No gnt_o[1] until IDLE.
  - gnt_o=10 arrives CLK_DIV+1 cycles after done_o=01.
- rst_i pulsed during bit 3 of a transfer:
  - Same cycle: cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, no done_o.
  - After release, req_i=11 grants requester 0 first.
- req_i=01 raised then dropped in the same cycle the FSM leaves GAP while busy -> no grant, cs_n_o stays high, busy_o stays 0.

Source files
------------

// File: rtl/spi_master_arb_if.sv
// Bus bundle for spi_master_arb.
// Requester side: req_i, data0_i, data1_i in; gnt_o, done_o, rdata_o, busy_o out.
// SPI side: sclk_o, cs_n_o, mosi_o out; miso_i in.
// Modport master is the controller's view; slave is the view of everything around it.
interface spi_master_arb_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [1:0]        req_i;
    logic [DATA_W-1:0] data0_i;
    logic [DATA_W-1:0] data1_i;
    logic [1:0]        gnt_o;
    logic [1:0]        done_o;
    logic [DATA_W-1:0] rdata_o;
    logic              busy_o;
    logic              sclk_o;
    logic              cs_n_o;
    logic              mosi_o;
    logic              miso_i;

    modport master (
        input  req_i, data0_i, data1_i, miso_i,
        output gnt_o, done_o, rdata_o, busy_o, sclk_o, cs_n_o, mosi_o
    );

    modport slave (
        output req_i, data0_i, data1_i, miso_i,
        input  gnt_o, done_o, rdata_o, busy_o, sclk_o, cs_n_o, mosi_o
    );
endinterface

// File: rtl/spi_master_arb.sv
// Two-requester SPI master (mode 0, MSB first) with round-robin arbitration.
// Ports:
//   clk_i  - system clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - spi_master_arb_if.master: requests/data in, grant/done/rdata/busy out,
//            SPI sclk/cs_n/mosi out, miso in
// Every output is a register. cs_n is low for 17*CLK_DIV cycles per transfer, followed by
// CLK_DIV cycles of gap before the controller returns to idle.
module spi_master_arb #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DATA_W  = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    spi_master_arb_if.master bus
);
    localparam int unsigned DivW = $clog2(CLK_DIV + 1);
    localparam int unsigned BitW = $clog2(DATA_W);

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StGap} state_t;

    state_t            r_state, w_state;
    logic [DivW-1:0]   r_div, w_div;
    logic [BitW-1:0]   r_bitcnt, w_bitcnt;
    logic [DATA_W-1:0] r_shreg, w_shreg;
    logic              r_ptr, w_ptr;
    logic              r_owner, w_owner;
    logic              r_sclk, w_sclk;
    logic              r_cs_n, w_cs_n;
    logic              r_mosi, w_mosi;
    logic [1:0]        r_gnt, w_gnt;
    logic [1:0]        r_done, w_done;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic              r_busy, w_busy;

    logic              w_winner;
    logic              w_div_end;
    logic [DATA_W-1:0] w_tx;

    // Pointer's requester wins if it is asking, otherwise the other one.
    assign w_winner  = bus.req_i[r_ptr] ? r_ptr : ~r_ptr;
    assign w_tx      = w_winner ? bus.data1_i : bus.data0_i;
    assign w_div_end = (r_div == DivW'(CLK_DIV - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_div    <= '0;
            r_bitcnt <= BitW'(DATA_W - 1);
            r_shreg  <= '0;
            r_ptr    <= 1'b0;
            r_owner  <= 1'b0;
            r_sclk   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_mosi   <= 1'b0;
            r_gnt    <= 2'b00;
            r_done   <= 2'b00;
            r_rdata  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_div    <= w_div;
            r_bitcnt <= w_bitcnt;
            r_shreg  <= w_shreg;
            r_ptr    <= w_ptr;
            r_owner  <= w_owner;
            r_sclk   <= w_sclk;
            r_cs_n   <= w_cs_n;
            r_mosi   <= w_mosi;
            r_gnt    <= w_gnt;
            r_done   <= w_done;
            r_rdata  <= w_rdata;
            r_busy   <= w_busy;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_div    = r_div;
        w_bitcnt = r_bitcnt;
        w_shreg  = r_shreg;
        w_ptr    = r_ptr;
        w_owner  = r_owner;
        w_sclk   = r_sclk;
        w_cs_n   = r_cs_n;
        w_mosi   = r_mosi;
        w_gnt    = 2'b00;
        w_done   = 2'b00;
        w_rdata  = r_rdata;
        w_busy   = r_busy;

        unique case (r_state)
            StIdle: begin
                if (|bus.req_i) begin
                    w_state  = StSetup;
                    w_gnt    = w_winner ? 2'b10 : 2'b01;
                    w_cs_n   = 1'b0;
                    w_busy   = 1'b1;
                    w_shreg  = w_tx;
                    w_mosi   = w_tx[DATA_W-1];
                    w_bitcnt = BitW'(DATA_W - 1);
                    w_div    = '0;
                    w_owner  = w_winner;
                    w_ptr    = ~w_winner;
                end
            end
            StSetup: begin
                // cs-to-first-edge setup: one half-period with sclk low
                if (w_div_end) begin
                    w_div   = '0;
                    w_state = StXfer;
                end else begin
                    w_div = r_div + DivW'(1);
                end
            end
            StXfer: begin
                if (w_div_end) begin
                    w_div = '0;
                    if (!r_sclk) begin
                        // Rising edge: shift miso in at the LSB; the next tx bit moves to
                        // the MSB and is driven out on the following falling edge.
                        w_sclk  = 1'b1;
                        w_shreg = {r_shreg[DATA_W-2:0], bus.miso_i};
                    end else begin
                        w_sclk = 1'b0;
                        if (r_bitcnt == '0) begin
                            w_cs_n  = 1'b1;
                            w_mosi  = 1'b0;
                            w_done  = r_owner ? 2'b10 : 2'b01;
                            w_rdata = r_shreg;
                            w_state = StGap;
                        end else begin
                            w_mosi   = r_shreg[DATA_W-1];
                            w_bitcnt = r_bitcnt - BitW'(1);
                        end
                    end
                end else begin
                    w_div = r_div + DivW'(1);
                end
            end
            StGap: begin
                if (w_div_end) begin
                    w_div   = '0;
                    w_state = StIdle;
                    w_busy  = 1'b0;
                end else begin
                    w_div = r_div + DivW'(1);
                end
            end
            default: w_state = StIdle;
        endcase
    end

    assign bus.gnt_o   = r_gnt;
    assign bus.done_o  = r_done;
    assign bus.rdata_o = r_rdata;
    assign bus.busy_o  = r_busy;
    assign bus.sclk_o  = r_sclk;
    assign bus.cs_n_o  = r_cs_n;
    assign bus.mosi_o  = r_mosi;
endmodule

// File: tb/tb_spi_master_arb.sv
module tb_spi_master_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic miso_one = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_arb_if #(.DATA_W(8)) ifa ();
    spi_master_arb_if #(.DATA_W(8)) ifb ();

    assign ifa.miso_i = miso_one ? 1'b1 : ifa.mosi_o;
    assign ifb.miso_i = ifb.mosi_o;

    spi_master_arb #(.CLK_DIV(2), .DATA_W(8)) u_dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
    spi_master_arb #(.CLK_DIV(1), .DATA_W(8)) u_dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

    typedef struct {
        logic [1:0] mask;
        int         gap;  // cycles from reference event, -1 = unchecked
    } gexp_t;

    typedef struct {
        logic [1:0] mask;
        logic [7:0] rdata;
        logic [7:0] tx;
    } dexp_t;

    gexp_t gq_a[$];
    dexp_t dq_a[$];
    gexp_t gq_b[$];
    dexp_t dq_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard for instance A (CLK_DIV=2)
    int         gnt_cyc_a = 0;
    int         done_cyc_a = 0;
    int         cs_cnt_a = 0;
    logic [7:0] mosi_cap_a = 8'h00;
    logic       sclk_prev_a = 1'b0;
    logic       busy_prev_a = 1'b0;
    logic       done_seen_a = 1'b0;

    always @(negedge clk) begin
        gexp_t g;
        dexp_t d;
        if (rst) begin
            sclk_prev_a = 1'b0;
            busy_prev_a = 1'b0;
            done_seen_a = 1'b0;
        end else begin
            if (ifa.gnt_o != 2'b00) begin
                if (gq_a.size() == 0) begin
                    chk("gnt_a_unexpected", 32'(ifa.gnt_o), 32'd0);
                end else begin
                    g = gq_a.pop_front();
                    chk("gnt_a_mask", 32'(ifa.gnt_o), 32'(g.mask));
                    if (g.gap >= 0) chk("gnt_a_after_done", cyc - done_cyc_a, g.gap);
                end
                gnt_cyc_a   = cyc;
                cs_cnt_a    = 0;
                mosi_cap_a  = 8'h00;
                done_seen_a = 1'b0;
            end
            if (!ifa.cs_n_o) cs_cnt_a++;
            if (ifa.sclk_o && !sclk_prev_a) mosi_cap_a = {mosi_cap_a[6:0], ifa.mosi_o};
            sclk_prev_a = ifa.sclk_o;
            if (ifa.cs_n_o && ifa.mosi_o) chk("mosi_a_idle", 32'(ifa.mosi_o), 32'd0);
            if (ifa.done_o != 2'b00) begin
                if (dq_a.size() == 0) begin
                    chk("done_a_unexpected", 32'(ifa.done_o), 32'd0);
                end else begin
                    d = dq_a.pop_front();
                    chk("done_a_mask", 32'(ifa.done_o), 32'(d.mask));
                    chk("rdata_a", 32'(ifa.rdata_o), 32'(d.rdata));
                    chk("mosi_a_bits", 32'(mosi_cap_a), 32'(d.tx));
                    chk("gnt_to_done_a", cyc - gnt_cyc_a, 34);
                    chk("cs_low_cycles_a", cs_cnt_a, 34);
                end
                done_cyc_a  = cyc;
                done_seen_a = 1'b1;
            end
            if (busy_prev_a && !ifa.busy_o && done_seen_a) begin
                chk("busy_fall_after_done_a", cyc - done_cyc_a, 2);
                done_seen_a = 1'b0;
            end
            busy_prev_a = ifa.busy_o;
        end
    end

    // Monitor / scoreboard for instance B (CLK_DIV=1)
    int   gnt_cyc_b = 0;
    int   n_gnt_b = 0;
    logic outstanding_b = 1'b0;

    always @(negedge clk) begin
        gexp_t g;
        dexp_t d;
        if (rst) begin
            outstanding_b = 1'b0;
        end else begin
            if (ifb.gnt_o != 2'b00) begin
                chk("overlap_b", 32'(outstanding_b), 32'd0);
                if (gq_b.size() == 0) begin
                    chk("gnt_b_unexpected", 32'(ifb.gnt_o), 32'd0);
                end else begin
                    g = gq_b.pop_front();
                    chk("gnt_b_order", 32'(ifb.gnt_o), 32'(g.mask));
                    if (g.gap >= 0) chk("gnt_b_spacing", cyc - gnt_cyc_b, g.gap);
                end
                gnt_cyc_b     = cyc;
                outstanding_b = 1'b1;
                n_gnt_b++;
            end
            if (ifb.done_o != 2'b00) begin
                if (dq_b.size() == 0) begin
                    chk("done_b_unexpected", 32'(ifb.done_o), 32'd0);
                end else begin
                    d = dq_b.pop_front();
                    chk("done_b_mask", 32'(ifb.done_o), 32'(d.mask));
                    chk("rdata_b", 32'(ifb.rdata_o), 32'(d.rdata));
                    chk("gnt_to_done_b", cyc - gnt_cyc_b, 17);
                end
                outstanding_b = 1'b0;
            end
        end
    end

    task automatic wait_gnt_a(input logic [1:0] m);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifa.gnt_o == m) return;
        end
        chk("timeout_gnt_a", 32'd0, 32'd1);
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifa.done_o != 2'b00) return;
        end
        chk("timeout_done_a", 32'd0, 32'd1);
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!ifa.busy_o) return;
        end
        chk("timeout_idle_a", 32'd0, 32'd1);
    endtask

    initial begin
        ifa.req_i = 2'b00; ifa.data0_i = 8'h00; ifa.data1_i = 8'h00;
        ifb.req_i = 2'b00; ifb.data0_i = 8'h81; ifb.data1_i = 8'h7E;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", 32'(ifa.sclk_o), 32'd0);
        chk("rst_cs_n", 32'(ifa.cs_n_o), 32'd1);
        chk("rst_mosi", 32'(ifa.mosi_o), 32'd0);
        chk("rst_gnt", 32'(ifa.gnt_o), 32'd0);
        chk("rst_done", 32'(ifa.done_o), 32'd0);
        chk("rst_busy", 32'(ifa.busy_o), 32'd0);
        chk("rst_rdata", 32'(ifa.rdata_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fairness on B: both requesting continuously, alternation 19 cycles apart
        gq_b.push_back('{2'b01, -1}); dq_b.push_back('{2'b01, 8'h81, 8'h81});
        gq_b.push_back('{2'b10, 19}); dq_b.push_back('{2'b10, 8'h7E, 8'h7E});
        gq_b.push_back('{2'b01, 19}); dq_b.push_back('{2'b01, 8'h81, 8'h81});
        gq_b.push_back('{2'b10, 19}); dq_b.push_back('{2'b10, 8'h7E, 8'h7E});
        ifb.req_i = 2'b11;
        for (int i = 0; i < 200 && n_gnt_b < 4; i++) @(negedge clk);
        chk("b_grant_count", n_gnt_b, 4);
        ifb.req_i = 2'b00;
        for (int i = 0; i < 50 && ifb.busy_o; i++) @(negedge clk);
        chk("b_idle", 32'(ifb.busy_o), 32'd0);

        // Loopback 0xA5 from requester 0
        @(posedge clk); #1;
        miso_one = 1'b0;
        ifa.data0_i = 8'hA5;
        gq_a.push_back('{2'b01, -1}); dq_a.push_back('{2'b01, 8'hA5, 8'hA5});
        ifa.req_i = 2'b01;
        wait_gnt_a(2'b01);
        ifa.req_i = 2'b00;
        wait_idle_a();

        // miso tied high, requester 1 sends 0x00
        @(posedge clk); #1;
        miso_one = 1'b1;
        ifa.data1_i = 8'h00;
        gq_a.push_back('{2'b10, -1}); dq_a.push_back('{2'b10, 8'hFF, 8'h00});
        ifa.req_i = 2'b10;
        wait_gnt_a(2'b10);
        ifa.req_i = 2'b00;
        wait_idle_a();

        // Requester 1 arrives mid-transfer: served CLK_DIV+1 cycles after done
        @(posedge clk); #1;
        miso_one = 1'b0;
        ifa.data0_i = 8'h3C;
        ifa.data1_i = 8'h96;
        gq_a.push_back('{2'b01, -1}); dq_a.push_back('{2'b01, 8'h3C, 8'h3C});
        gq_a.push_back('{2'b10, 3});  dq_a.push_back('{2'b10, 8'h96, 8'h96});
        ifa.req_i = 2'b01;
        wait_gnt_a(2'b01);
        ifa.req_i = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        ifa.req_i = 2'b10;
        wait_gnt_a(2'b10);
        ifa.req_i = 2'b00;
        wait_idle_a();

        // Request pulsed only across the GAP->IDLE edge: never granted
        @(posedge clk); #1;
        ifa.data0_i = 8'h5A;
        gq_a.push_back('{2'b01, -1}); dq_a.push_back('{2'b01, 8'h5A, 8'h5A});
        ifa.req_i = 2'b01;
        wait_gnt_a(2'b01);
        ifa.req_i = 2'b00;
        wait_done_a();
        @(posedge clk); #1;
        ifa.req_i = 2'b01;
        @(posedge clk); #1;
        ifa.req_i = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("pulse_gnt", 32'(ifa.gnt_o), 32'd0);
            chk("pulse_cs_n", 32'(ifa.cs_n_o), 32'd1);
            chk("pulse_busy", 32'(ifa.busy_o), 32'd0);
        end

        // Reset during bit 3 of a transfer
        @(posedge clk); #1;
        ifa.data0_i = 8'hF0;
        gq_a.push_back('{2'b01, -1});
        ifa.req_i = 2'b01;
        wait_gnt_a(2'b01);
        ifa.req_i = 2'b00;
        repeat (19) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_cs_n", 32'(ifa.cs_n_o), 32'd1);
        chk("midrst_sclk", 32'(ifa.sclk_o), 32'd0);
        chk("midrst_mosi", 32'(ifa.mosi_o), 32'd0);
        chk("midrst_busy", 32'(ifa.busy_o), 32'd0);
        chk("midrst_done", 32'(ifa.done_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ifa.data0_i = 8'h11;
        ifa.data1_i = 8'h22;
        gq_a.push_back('{2'b01, -1}); dq_a.push_back('{2'b01, 8'h11, 8'h11});
        gq_a.push_back('{2'b10, 3});  dq_a.push_back('{2'b10, 8'h22, 8'h22});
        ifa.req_i = 2'b11;
        wait_gnt_a(2'b01);
        ifa.req_i = 2'b10;
        wait_gnt_a(2'b10);
        ifa.req_i = 2'b00;
        wait_idle_a();
        repeat (4) @(negedge clk);

        chk("gq_a_left", gq_a.size(), 0);
        chk("dq_a_left", dq_a.size(), 0);
        chk("gq_b_left", gq_b.size(), 0);
        chk("dq_b_left", dq_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
